// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access controller. Converts EX/MEM
//               load/store controls into a ready-handshaked memory request,
//               steers byte/half/word lanes, formats load data and stalls
//               the pipeline until the memory responds or times out.
//               Optional statistics counters: define MEM_ACCESS_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] ex_mem_write_data,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        access_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] stall_count
`endif
);

  // Last WAIT-cycle count value before the access is abandoned.
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;

  // Request fields captured at issue so WAIT presents a constant request.
  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  // Decode of the current EX/MEM instruction.
  logic        is_access;
  logic        is_load;
  logic        bad_funct3;
  logic        misaligned;
  logic        bad_access;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;

  // Controls from the next-state logic.
  logic        fault_set;
  logic        capture;
  logic        latch_req;
  logic        cnt_inc;
  logic [2:0]  fmt_funct3;
  logic [1:0]  fmt_off;
  logic [31:0] rdata_shift;
  logic [31:0] load_fmt;

  assign is_access = ex_mem_memread | ex_mem_memwrite;
  assign is_load   = ex_mem_memread;
  assign cur_addr  = {alu_result_ex_mem[31:2], 2'b00};

  // Decode legality, lane strobes and replicated store data.
  always_comb begin
    bad_funct3 = 1'b0;
    misaligned = 1'b0;
    cur_wstrb  = 4'b0000;
    cur_wdata  = 32'd0;
    if (is_load) begin
      bad_funct3 = (ex_mem_funct3[1:0] == 2'b11) || (ex_mem_funct3[2] && ex_mem_funct3[1]);
    end else begin
      bad_funct3 = ex_mem_funct3[2] || (ex_mem_funct3[1:0] == 2'b11);
    end
    case (ex_mem_funct3[1:0])
      2'b01:   misaligned = alu_result_ex_mem[0];
      2'b10:   misaligned = (alu_result_ex_mem[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (!is_load) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          cur_wstrb = 4'b0001 << alu_result_ex_mem[1:0];
          cur_wdata = {4{ex_mem_write_data[7:0]}};
        end
        2'b01: begin
          cur_wstrb = alu_result_ex_mem[1] ? 4'b1100 : 4'b0011;
          cur_wdata = {2{ex_mem_write_data[15:0]}};
        end
        default: begin
          cur_wstrb = 4'b1111;
          cur_wdata = ex_mem_write_data;
        end
      endcase
    end
  end

  assign bad_access = bad_funct3 | misaligned;

  // Format the returned word according to size/sign and byte offset.
  assign fmt_funct3  = (state == S_WAIT) ? lat_funct3 : ex_mem_funct3;
  assign fmt_off     = (state == S_WAIT) ? lat_off    : alu_result_ex_mem[1:0];
  assign rdata_shift = dmem_rdata >> {fmt_off, 3'b000};

  always_comb begin
    case (fmt_funct3[1:0])
      2'b00:   load_fmt = {{24{~fmt_funct3[2] & rdata_shift[7]}},  rdata_shift[7:0]};
      2'b01:   load_fmt = {{16{~fmt_funct3[2] & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // Next-state and request/stall outputs; nothing is driven while in reset.
  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    dmem_wstrb = 4'b0000;
    mem_stall  = 1'b0;
    fault_set  = 1'b0;
    capture    = 1'b0;
    latch_req  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rst && is_access) begin
          if (bad_access) begin
            fault_set = 1'b1;
          end else begin
            dmem_req   = 1'b1;
            dmem_we    = ~is_load;
            dmem_addr  = cur_addr;
            dmem_wdata = cur_wdata;
            dmem_wstrb = cur_wstrb;
            mem_stall  = 1'b1;
            latch_req  = 1'b1;
            if (dmem_ready) begin
              state_nxt = S_DONE;
              capture   = is_load;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!rst) begin
          dmem_req   = 1'b1;
          dmem_we    = ~lat_load;
          dmem_addr  = lat_addr;
          dmem_wdata = lat_wdata;
          dmem_wstrb = lat_wstrb;
          mem_stall  = 1'b1;
          if (dmem_ready) begin
            state_nxt = S_DONE;
            capture   = lat_load;
          end else if (wait_cnt == C_TMO_LAST) begin
            state_nxt = S_IDLE;
            fault_set = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, fault pulse, timeout counter, captured request and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      access_fault <= 1'b0;
      wait_cnt     <= 8'd0;
      read_data    <= 32'd0;
      lat_load     <= 1'b0;
      lat_funct3   <= 3'd0;
      lat_off      <= 2'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_wstrb    <= 4'd0;
    end else begin
      state        <= state_nxt;
      access_fault <= fault_set;
      wait_cnt     <= cnt_inc ? wait_cnt + 8'd1 : 8'd0;
      if (capture) begin
        read_data <= load_fmt;
      end
      if (latch_req) begin
        lat_load   <= is_load;
        lat_funct3 <= ex_mem_funct3;
        lat_off    <= alu_result_ex_mem[1:0];
        lat_addr   <= cur_addr;
        lat_wdata  <= cur_wdata;
        lat_wstrb  <= cur_wstrb;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic done_entry;
  logic done_load;

  assign done_entry = (state != S_DONE) && (state_nxt == S_DONE);
  assign done_load  = (state == S_WAIT) ? lat_load : is_load;

  // Completed-access and stall-cycle statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count  <= 32'd0;
      store_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (done_entry && done_load) begin
        load_count <= load_count + 32'd1;
      end
      if (done_entry && !done_load) begin
        store_count <= store_count + 32'd1;
      end
      if (mem_stall) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Randomized self-checking bench for mem_access_unit with a
//               transaction-level reference model of lane steering, load
//               formatting, fault rules and handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TMO   = 4;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] alu_result_ex_mem;
  logic [31:0] ex_mem_write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        access_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
  logic [31:0] stall_count;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_rd   = 32'd0;
  int          exp_loads = 0, exp_stores = 0, exp_stalls = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_funct3     (ex_mem_funct3),
    .alu_result_ex_mem (alu_result_ex_mem),
    .ex_mem_write_data (ex_mem_write_data),
    .read_data         (read_data),
    .mem_stall         (mem_stall),
    .access_fault      (access_fault),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .load_count        (load_count),
    .store_count       (store_count),
    .stall_count       (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_mem_memread  = 1'b0;
    ex_mem_memwrite = 1'b0;
    dmem_ready      = 1'b0;
    dmem_rdata      = $urandom;
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit ref_bad(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit ok_f3;
    int n;
    if (ld) ok_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else    ok_f3 = (f3 <= 2);
    n = acc_bytes(f3);
    return !ok_f3 || ((a % n) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int     n;
    longint mask, v;
    n    = acc_bytes(f3);
    mask = (longint'(1) << (8 * n)) - 1;
    v    = (longint'(rd) >> (8 * (a % 4))) & mask;
    if (f3 < 4 && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_bytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    n = acc_bytes(f3);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // One EX/MEM instruction; k = cycle (0 = issue cycle) on which memory is ready.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdat, input int k);
    bit ld;
    ex_mem_memread    = rd;
    ex_mem_memwrite   = wr;
    ex_mem_funct3     = f3;
    alu_result_ex_mem = addr;
    ex_mem_write_data = wd;
    ld = rd;
    if (!rd && !wr) begin
      @(negedge clk);
      check("nop_req", dmem_req, 0);
      check("nop_stall", mem_stall, 0);
      tick();
      return;
    end
    if (ref_bad(ld, f3, addr)) begin
      @(negedge clk);
      check("bad_req", dmem_req, 0);
      check("bad_stall", mem_stall, 0);
      check("bad_fault_early", access_fault, 0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("bad_fault", access_fault, 1);
      check("bad_stall2", mem_stall, 0);
      check("bad_rd", read_data, exp_rd);
      tick();
      return;
    end
    for (int i = 0; i <= TMO; i++) begin
      dmem_ready = (i == k);
      dmem_rdata = (i == k) ? rdat : $urandom;
      @(negedge clk);
      check("req", dmem_req, 1);
      check("stall", mem_stall, 1);
      check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("we", dmem_we, {31'd0, !ld});
      check("wstrb", dmem_wstrb, ld ? 4'b0000 : ref_strb(f3, addr));
      if (!ld) check("wdata", dmem_wdata, ref_wdata(f3, wd));
      check("fault_busy", access_fault, 0);
      check("rd_hold", read_data, exp_rd);
      exp_stalls++;
      tick();
      if (i == k) break;
    end
    dmem_ready = 1'b0;
    if (k <= TMO) begin
      if (ld) begin
        exp_rd = ref_load(f3, addr, rdat);
        exp_loads++;
      end else begin
        exp_stores++;
      end
      @(negedge clk);
      check("done_req", dmem_req, 0);
      check("done_stall", mem_stall, 0);
      check("done_rd", read_data, exp_rd);
      tick();
      idle_inputs();
    end else begin
      idle_inputs();
      @(negedge clk);
      check("tmo_fault", access_fault, 1);
      check("tmo_req", dmem_req, 0);
      check("tmo_stall", mem_stall, 0);
      check("tmo_rd", read_data, exp_rd);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_mem_funct3     = 3'd0;
    alu_result_ex_mem = 32'd0;
    ex_mem_write_data = 32'd0;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd", read_data, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_fault", access_fault, 0);
    check("rst_req", dmem_req, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    tick();

    // Directed cases
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);   // LB
    check("lb_val", exp_rd, 32'hFFFF_FF80);
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'hABCD_0000, 3);   // LHU
    check("lhu_val", exp_rd, 32'h0000_ABCD);
    run_access(0, 1, 3'b000, 32'h21, 32'h5A, 32'h0, 0);           // SB
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);           // LW misaligned
    run_access(1, 1, 3'b010, 32'h40, 32'h0, 32'h0, NEVER);        // timeout
    run_access(1, 0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1);    // LW after timeout
    run_access(0, 1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0, 2);    // SH upper
    run_access(0, 1, 3'b100, 32'h08, 32'h0, 32'h0, 0);            // illegal store funct3
    run_access(1, 0, 3'b011, 32'h08, 32'h0, 32'h0, 0);            // illegal load funct3
    run_access(0, 0, 3'b010, 32'h08, 32'h0, 32'h0, 0);            // non-memory

    // Reset while waiting
    ex_mem_memread = 1'b1; ex_mem_memwrite = 1'b0;
    ex_mem_funct3 = 3'b010; alu_result_ex_mem = 32'h200;
    @(negedge clk);
    check("rw_req0", dmem_req, 1);
    tick();
    @(negedge clk);
    check("rw_req1", dmem_req, 1);
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    exp_rd = 32'd0; exp_loads = 0; exp_stores = 0; exp_stalls = 0;
    @(negedge clk);
    check("rw_req", dmem_req, 0);
    check("rw_stall", mem_stall, 0);
    check("rw_rd", read_data, 0);
    check("rw_fault", access_fault, 0);
    tick();
    run_access(1, 0, 3'b010, 32'h200, 32'h0, 32'h1357_9BDF, 0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin rd = 0; wr = 0; end
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      k = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TMO));
      run_access(rd, wr, f3, a, $urandom, $urandom, k);
    end

`ifdef MEM_ACCESS_STATS_EN
    @(negedge clk);
    check("stat_loads", load_count, exp_loads);
    check("stat_stores", store_count, exp_stores);
    check("stat_stalls", stall_count, exp_stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
